// File: rtl/imm_gen_stage_pkg.sv
// Shared definitions for the immediate-generation stage: format select codes,
// skid-buffer state encoding and the datapath width legality check.
package imm_gen_stage_pkg;

  // Immediate format select codes
  localparam logic [2:0] SEL_NONE  = 3'b000;
  localparam logic [2:0] SEL_I     = 3'b001;
  localparam logic [2:0] SEL_S     = 3'b010;
  localparam logic [2:0] SEL_B     = 3'b011;
  localparam logic [2:0] SEL_U     = 3'b100;
  localparam logic [2:0] SEL_J     = 3'b101;
  localparam logic [2:0] SEL_ZIMM  = 3'b110;
  localparam logic [2:0] SEL_SHAMT = 3'b111;

  // Occupancy of the two-entry skid buffer
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_e;

  // Only RV32 and RV64 datapaths are supported
  function automatic bit xlen_legal(int unsigned xlen);
    return (xlen == 32) || (xlen == 64);
  endfunction

endpackage

// File: rtl/imm_extend.sv
// Combinational immediate extraction and extension for all RISC-V formats.
module imm_extend
  import imm_gen_stage_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int SEL_W = 3
) (
  input  logic [31:0]      inst,
  input  logic [SEL_W-1:0] sel,
  output logic [XLEN-1:0]  imm
);

  logic [31:0] raw;
  logic        sign_ext;
  logic        unused_opcode;

  // The opcode field never contributes to any immediate
  assign unused_opcode = ^inst[6:0];

  // Gather the 32-bit immediate for the selected format, then widen to XLEN
  always_comb begin
    raw      = 32'b0;
    sign_ext = 1'b0;
    case (sel)
      SEL_I: begin
        raw      = {{20{inst[31]}}, inst[31:20]};
        sign_ext = 1'b1;
      end
      SEL_S: begin
        raw      = {{20{inst[31]}}, inst[31:25], inst[11:7]};
        sign_ext = 1'b1;
      end
      SEL_B: begin
        raw      = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
        sign_ext = 1'b1;
      end
      SEL_U: begin
        raw      = {inst[31:12], 12'b0};
        sign_ext = 1'b1;
      end
      SEL_J: begin
        raw      = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
        sign_ext = 1'b1;
      end
      SEL_ZIMM: begin
        raw = {27'b0, inst[19:15]};
      end
      SEL_SHAMT: begin
        if (XLEN == 64) raw = {26'b0, inst[25:20]};
        else            raw = {27'b0, inst[24:20]};
      end
      default: begin
        raw = 32'b0;
      end
    endcase
    imm = sign_ext ? XLEN'($signed(raw)) : XLEN'(raw);
  end

endmodule

// File: rtl/imm_gen_stage.sv
// Immediate-generation pipeline stage: extends the immediate on the input side
// and holds results in a two-entry skid buffer so in_ready can be registered
// without losing throughput.
module imm_gen_stage
  import imm_gen_stage_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int SEL_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      inst,
  input  logic [SEL_W-1:0] sel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  imm,
  output logic [SEL_W-1:0] out_sel
);

  if (!xlen_legal(XLEN)) begin : g_bad_xlen
    $error("imm_gen_stage: XLEN must be 32 or 64");
  end

  state_e           state_q, state_d;
  logic             in_ready_q, out_valid_q;
  logic [XLEN-1:0]  main_imm_q, skid_imm_q;
  logic [SEL_W-1:0] main_sel_q, skid_sel_q;
  logic [XLEN-1:0]  ext_imm;
  logic             accept, consume;
  logic             load_main_new, load_main_skid, load_skid;

  imm_extend #(
    .XLEN  (XLEN),
    .SEL_W (SEL_W)
  ) u_imm_extend (
    .inst (inst),
    .sel  (sel),
    .imm  (ext_imm)
  );

  assign accept    = in_valid & in_ready_q;
  assign consume   = out_valid_q & out_ready;
  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign imm       = main_imm_q;
  assign out_sel   = main_sel_q;

  // Decide next occupancy and which register each entry lands in
  always_comb begin
    state_d        = state_q;
    load_main_new  = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    case (state_q)
      ST_EMPTY: begin
        if (accept) begin
          state_d       = ST_ONE;
          load_main_new = 1'b1;
        end
      end
      ST_ONE: begin
        if (accept && consume) begin
          load_main_new = 1'b1;
        end else if (accept) begin
          state_d   = ST_TWO;
          load_skid = 1'b1;
        end else if (consume) begin
          state_d = ST_EMPTY;
        end
      end
      ST_TWO: begin
        if (consume) begin
          state_d        = ST_ONE;
          load_main_skid = 1'b1;
        end
      end
      default: begin
        state_d = ST_EMPTY;
      end
    endcase
  end

  // Register occupancy, handshake outputs and buffered entries; flush drops all
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_EMPTY;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      main_imm_q  <= '0;
      main_sel_q  <= '0;
      skid_imm_q  <= '0;
      skid_sel_q  <= '0;
    end else if (flush) begin
      state_q     <= ST_EMPTY;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= (state_d != ST_TWO);
      out_valid_q <= (state_d != ST_EMPTY);
      if (load_main_new) begin
        main_imm_q <= ext_imm;
        main_sel_q <= sel;
      end else if (load_main_skid) begin
        main_imm_q <= skid_imm_q;
        main_sel_q <= skid_sel_q;
      end
      if (load_skid) begin
        skid_imm_q <= ext_imm;
        skid_sel_q <= sel;
      end
    end
  end

endmodule

// File: tb/tb_imm_gen_stage.sv
// Directed bench for imm_gen_stage: a vector table run through 32- and 64-bit
// instances, plus backpressure, flush and reset sequences.
module tb_imm_gen_stage;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, out_ready;
  logic [31:0] inst;
  logic [2:0]  sel;

  logic        in_ready32, out_valid32, in_ready64, out_valid64;
  logic [31:0] imm32;
  logic [63:0] imm64;
  logic [2:0]  out_sel32, out_sel64;

  int testsRun = 0;
  int testsFailed = 0;

  typedef struct {
    logic [31:0] inst;
    logic [2:0]  sel;
    logic [31:0] exp32;
    logic [63:0] exp64;
  } vec_t;

  vec_t vecs[12];

  always #5 clk = ~clk;

  imm_gen_stage #(.XLEN(32), .SEL_W(3)) dut32 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready32),
    .inst(inst), .sel(sel), .out_valid(out_valid32), .out_ready(out_ready),
    .imm(imm32), .out_sel(out_sel32)
  );

  imm_gen_stage #(.XLEN(64), .SEL_W(3)) dut64 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready64),
    .inst(inst), .sel(sel), .out_valid(out_valid64), .out_ready(out_ready),
    .imm(imm64), .out_sel(out_sel64)
  );

  // Compare one value and record the outcome
  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  // Advance one clock, landing on the falling edge for sampling and driving
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Present one input entry for the next rising edge
  task automatic applyStimulus(input logic [31:0] i, input logic [2:0] s, input logic v);
    inst     = i;
    sel      = s;
    in_valid = v;
  endtask

  initial begin
    vecs[0]  = '{32'hFFF00093, 3'b001, 32'hFFFFFFFF, 64'hFFFFFFFFFFFFFFFF};
    vecs[1]  = '{32'hFE000EE3, 3'b011, 32'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC};
    vecs[2]  = '{32'hFE000EE3, 3'b010, 32'hFFFFFFFD, 64'hFFFFFFFFFFFFFFFD};
    vecs[3]  = '{32'h80000037, 3'b100, 32'h80000000, 64'hFFFFFFFF80000000};
    vecs[4]  = '{32'h03F0D093, 3'b111, 32'h0000001F, 64'h000000000000003F};
    vecs[5]  = '{32'h000F8073, 3'b110, 32'h0000001F, 64'h000000000000001F};
    vecs[6]  = '{32'hFFFFFFFF, 3'b110, 32'h0000001F, 64'h000000000000001F};
    vecs[7]  = '{32'hFFFFFFFF, 3'b000, 32'h00000000, 64'h0000000000000000};
    vecs[8]  = '{32'h800000EF, 3'b101, 32'hFFF00000, 64'hFFFFFFFFFFF00000};
    vecs[9]  = '{32'h7FFFF06F, 3'b101, 32'h000FFFFE, 64'h00000000000FFFFE};
    vecs[10] = '{32'h00100093, 3'b001, 32'h00000001, 64'h0000000000000001};
    vecs[11] = '{32'h00A12423, 3'b010, 32'h00000008, 64'h0000000000000008};

    rst = 1'b1; flush = 1'b0; out_ready = 1'b1;
    applyStimulus(32'h0, 3'b000, 1'b0);
    @(negedge clk);
    step();
    rst = 1'b0;

    // Reset state
    checkOutput("reset out_valid", {63'b0, out_valid32}, 64'd0);
    checkOutput("reset in_ready", {63'b0, in_ready32}, 64'd1);
    checkOutput("reset imm32", {32'b0, imm32}, 64'd0);
    checkOutput("reset out_sel", {61'b0, out_sel32}, 64'd0);

    // Table of single transfers, one-cycle latency, downstream always ready
    for (int k = 0; k < 12; k++) begin
      applyStimulus(vecs[k].inst, vecs[k].sel, 1'b1);
      step();
      applyStimulus(32'h0, 3'b000, 1'b0);
      checkOutput($sformatf("vec%0d out_valid", k), {63'b0, out_valid32}, 64'd1);
      checkOutput($sformatf("vec%0d imm32", k), {32'b0, imm32}, {32'b0, vecs[k].exp32});
      checkOutput($sformatf("vec%0d imm64", k), imm64, vecs[k].exp64);
      checkOutput($sformatf("vec%0d out_sel", k), {61'b0, out_sel64}, {61'b0, vecs[k].sel});
      step();
      checkOutput($sformatf("vec%0d drained", k), {63'b0, out_valid32}, 64'd0);
    end

    // Backpressure: three back-to-back entries with downstream stalled
    out_ready = 1'b0;
    applyStimulus(32'h00100093, 3'b001, 1'b1);
    step();
    checkOutput("bp in_ready after 1", {63'b0, in_ready32}, 64'd1);
    applyStimulus(32'h00200093, 3'b001, 1'b1);
    step();
    checkOutput("bp in_ready after 2", {63'b0, in_ready32}, 64'd0);
    applyStimulus(32'h00300093, 3'b001, 1'b1);
    step();
    checkOutput("bp third held", {63'b0, in_ready32}, 64'd0);
    checkOutput("bp imm stable 1", {32'b0, imm32}, 64'd1);
    step();
    checkOutput("bp imm stable 1b", {32'b0, imm32}, 64'd1);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    checkOutput("bp second out", {32'b0, imm32}, 64'd2);
    checkOutput("bp in_ready reopens", {63'b0, in_ready32}, 64'd1);
    step();
    applyStimulus(32'h0, 3'b000, 1'b0);
    checkOutput("bp imm stable 2", {32'b0, imm32}, 64'd2);
    out_ready = 1'b1;
    step();
    checkOutput("bp third out", {32'b0, imm32}, 64'd3);
    checkOutput("bp third valid", {63'b0, out_valid32}, 64'd1);
    step();
    checkOutput("bp drained", {63'b0, out_valid32}, 64'd0);

    // Flush while holding two entries with a new input presented
    out_ready = 1'b0;
    applyStimulus(32'h00400093, 3'b001, 1'b1);
    step();
    step();
    checkOutput("flush pre state TWO", {63'b0, in_ready32}, 64'd0);
    applyStimulus(32'h00700093, 3'b001, 1'b1);
    flush = 1'b1;
    step();
    flush = 1'b0;
    applyStimulus(32'h0, 3'b000, 1'b0);
    checkOutput("flush out_valid", {63'b0, out_valid32}, 64'd0);
    checkOutput("flush in_ready", {63'b0, in_ready32}, 64'd1);
    out_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      checkOutput($sformatf("flush nothing emerges %0d", c), {63'b0, out_valid32}, 64'd0);
    end

    // Reset while holding one entry, then a fresh entry afterwards
    out_ready = 1'b0;
    applyStimulus(32'h00500093, 3'b001, 1'b1);
    step();
    applyStimulus(32'h0, 3'b000, 1'b0);
    checkOutput("rst pre out_valid", {63'b0, out_valid32}, 64'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    checkOutput("rst out_valid", {63'b0, out_valid32}, 64'd0);
    checkOutput("rst imm32", {32'b0, imm32}, 64'd0);
    checkOutput("rst imm64", imm64, 64'd0);
    checkOutput("rst out_sel", {61'b0, out_sel32}, 64'd0);
    out_ready = 1'b1;
    applyStimulus(32'h00600093, 3'b001, 1'b1);
    step();
    applyStimulus(32'h0, 3'b000, 1'b0);
    checkOutput("post rst valid", {63'b0, out_valid32}, 64'd1);
    checkOutput("post rst imm", {32'b0, imm32}, 64'd6);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
